// File: rtl/usb_frame_ctrl.sv
// usb_frame_ctrl: frame-level sequencer for the USB byte reader.
// Hunts for a sync byte, parses cmd/len/payload/checksum frames, writes the
// payload into an external buffer and holds the reader while a good frame
// waits for the consumer's acknowledge.
module usb_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 64,
  parameter int         ADDR_W    = 6,
  parameter int         TIMEOUT   = 1000000,
  parameter int         TO_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [7:0]        sync_miss,
  output logic              busy,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TO   = 2'd3;

  state_t          state_q, state_d;
  logic            accept;
  logic            timed;
  logic            to_expire;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      sum;
  logic [7:0]      idx;
  logic [7:0]      csum_chk;
  logic            err_d;
  logic [1:0]      code_d;
  logic            wr_d;
  logic            miss_d;

  // Saturating increment for the discarded-byte counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The registered hold gates the strobe, so bytes offered while held vanish.
  assign accept    = byte_valid & ~hold;
  assign timed     = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign to_expire = timed && !accept && (to_cnt == TO_LAST);
  assign csum_chk  = sum + byte_in;
  assign state     = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode plus the one-cycle events (error, write, sync miss).
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    code_d  = 2'd0;
    wr_d    = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (byte_in == SYNC_BYTE) state_d = S_CMD;
          else                      miss_d  = 1'b1;
        end
      end
      S_CMD: begin
        if (accept)         state_d = S_LEN;
        else if (to_expire) begin err_d = 1'b1; code_d = ERR_TO; end
      end
      S_LEN: begin
        if (accept) begin
          if (byte_in > MAX_LEN_B)  begin err_d = 1'b1; code_d = ERR_LEN; end
          else if (byte_in == 8'd0) state_d = S_CSUM;
          else                      state_d = S_PAYLOAD;
        end else if (to_expire) begin
          err_d = 1'b1; code_d = ERR_TO;
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          wr_d = 1'b1;
          if (idx + 8'd1 == frame_len) state_d = S_CSUM;
        end else if (to_expire) begin
          err_d = 1'b1; code_d = ERR_TO;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (csum_chk == 8'd0) state_d = S_DONE;
          else                  begin err_d = 1'b1; code_d = ERR_CSUM; end
        end else if (to_expire) begin
          err_d = 1'b1; code_d = ERR_TO;
        end
      end
      S_DONE: begin
        if (frame_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (err_d) state_d = S_IDLE;
  end

  // Registered outputs, frame fields, running checksum, index and timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold        <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'd0;
      frame_valid <= 1'b0;
      frame_cmd   <= 8'd0;
      frame_len   <= 8'd0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      sync_miss   <= 8'd0;
      busy        <= 1'b0;
      to_cnt      <= '0;
      sum         <= 8'd0;
      idx         <= 8'd0;
    end else begin
      hold        <= (state_d == S_DONE);
      frame_valid <= (state_d == S_DONE);
      busy        <= (state_d != S_IDLE);
      wr_en       <= wr_d;
      frame_err   <= err_d;
      if (err_d)  err_code  <= code_d;
      if (miss_d) sync_miss <= sat_inc8(sync_miss);

      if (accept || !timed || to_expire) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;

      if (accept) begin
        case (state_q)
          S_CMD: begin
            frame_cmd <= byte_in;
            sum       <= byte_in;
          end
          S_LEN: begin
            frame_len <= byte_in;
            sum       <= sum + byte_in;
            idx       <= 8'd0;
          end
          S_PAYLOAD: begin
            wr_addr <= idx[ADDR_W-1:0];
            wr_data <= byte_in;
            sum     <= sum + byte_in;
            idx     <= idx + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_frame_ctrl.sv
// Testbench for usb_frame_ctrl: directed scenarios plus randomized frame
// streams checked against a byte-level frame parser model.
module tb_usb_frame_ctrl;

  localparam int SYNC = 8'hA5;
  localparam int MAXL = 64;
  localparam int GAP  = 12;

  logic       clk;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       hold;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic       frame_ack;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] sync_miss;
  logic       busy;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  int wq[$];
  int eq[$];
  int exp_w[$];
  int exp_e[$];
  int exp_fv, exp_cmd, exp_len, exp_miss;

  usb_frame_ctrl #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(64), .ADDR_W(6), .TIMEOUT(100), .TO_W(8)
  ) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
    .frame_ack(frame_ack), .frame_err(frame_err), .err_code(err_code),
    .sync_miss(sync_miss), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor on the falling edge: buffer writes and error pulses.
  always @(negedge clk) begin
    if (wr_en)     wq.push_back(int'({wr_addr, wr_data}));
    if (frame_err) eq.push_back(int'(err_code));
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq.delete();
    eq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; byte_valid = 1'b0; frame_ack = 1'b0; byte_in = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    clear_q();
  endtask

  task automatic send(input logic [7:0] b, input int gap = GAP);
    byte_in = b; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  // Byte-level reference: parse the stream as whole frames by slicing.
  task automatic model(input int s[$]);
    int i, cmd, len, tot;
    exp_w.delete(); exp_e.delete();
    exp_fv = 0;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        exp_miss = (exp_miss < 255) ? exp_miss + 1 : 255;
        i++;
      end else begin
        cmd = s[i+1]; len = s[i+2]; i += 3;
        if (len > MAXL) exp_e.push_back(2);
        else begin
          tot = cmd + len;
          for (int k = 0; k < len; k++) begin
            exp_w.push_back((k << 8) | s[i+k]);
            tot += s[i+k];
          end
          i += len;
          tot += s[i];
          i++;
          if (tot % 256 != 0) exp_e.push_back(1);
          else begin exp_fv = 1; exp_cmd = cmd; exp_len = len; end
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({hold, wr_en, wr_addr, wr_data, frame_valid, frame_cmd, frame_len,
         frame_err, err_code, sync_miss, busy, state} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {hold, wr_en, wr_addr, wr_data,
               frame_valid, frame_cmd, frame_len, frame_err, err_code, sync_miss, busy, state});
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] f[6] = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h77};
    do_reset();
    foreach (f[i]) send(f[i]);
    n_cmp++;
    if (wq.size() != 2 || wq[0] != 'h033 || wq[1] != 'h144) begin
      n_bad++; $display("FAIL good_writes: got %0d writes want 2 (0:33 1:44)", wq.size());
    end
    n_cmp++;
    if ({frame_valid, hold, busy, frame_cmd, frame_len, state} !== {3'b111, 8'h10, 8'h02, 3'd5}) begin
      n_bad++; $display("FAIL good_done: got v=%b h=%b cmd=%h len=%h st=%0d want 1 1 10 02 5",
                        frame_valid, hold, frame_cmd, frame_len, state);
    end
    repeat (20) tick();
    n_cmp++;
    if ({frame_valid, hold, frame_cmd, frame_len} !== {2'b11, 8'h10, 8'h02}) begin
      n_bad++; $display("FAIL good_stable: got v=%b h=%b cmd=%h len=%h", frame_valid, hold, frame_cmd, frame_len);
    end
    ack();
    n_cmp++;
    if ({frame_valid, hold, state} !== {2'b00, 3'd0}) begin
      n_bad++; $display("FAIL good_release: got v=%b h=%b st=%0d want 0 0 0", frame_valid, hold, state);
    end
    send(8'hA5); send(8'h20); send(8'h00); send(8'hE0);
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_len} !== {1'b1, 8'h20, 8'h00} || wq.size() != 2) begin
      n_bad++; $display("FAIL back_to_back: got v=%b cmd=%h len=%h writes=%0d want 1 20 00 2",
                        frame_valid, frame_cmd, frame_len, wq.size());
    end
    ack();
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[6] = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h78};
    do_reset();
    foreach (f[i]) send(f[i]);
    n_cmp++;
    if (eq.size() != 1 || err_code !== 2'd1) begin
      n_bad++; $display("FAIL bad_csum_err: got pulses=%0d code=%0d want 1 1", eq.size(), err_code);
    end
    n_cmp++;
    if ({frame_valid, hold, state} !== 5'd0) begin
      n_bad++; $display("FAIL bad_csum_state: got v=%b h=%b st=%0d want 0 0 0", frame_valid, hold, state);
    end
  endtask

  task automatic test_len_over();
    do_reset();
    send(8'hA5); send(8'h10); send(8'h41);
    n_cmp++;
    if (eq.size() != 1 || eq[0] != 2 || wq.size() != 0 || state !== 3'd0) begin
      n_bad++; $display("FAIL len_over: got pulses=%0d code=%0d writes=%0d st=%0d want 1 2 0 0",
                        eq.size(), err_code, wq.size(), state);
    end
    send(8'hA5); send(8'h20); send(8'h00); send(8'hE0);
    n_cmp++;
    if ({frame_valid, frame_len, err_code} !== {1'b1, 8'h00, 2'd2}) begin
      n_bad++; $display("FAIL len_over_recover: got v=%b len=%h code=%0d want 1 00 2",
                        frame_valid, frame_len, err_code);
    end
    ack();
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    send(8'hA5);
    byte_in = 8'h10; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    k = 1;
    while (!frame_err && k < 200) begin tick(); k++; end
    n_cmp++;
    if (!frame_err || k < 100 || k > 101 || err_code !== 2'd3) begin
      n_bad++; $display("FAIL timeout_pulse: got err=%b at cycle %0d code=%0d want err at 100..101 code 3",
                        frame_err, k, err_code);
    end
    tick();
    n_cmp++;
    if ({frame_err, state, busy} !== 5'd0 || eq.size() != 1) begin
      n_bad++; $display("FAIL timeout_idle: got err=%b st=%0d busy=%b pulses=%0d want 0 0 0 1",
                        frame_err, state, busy, eq.size());
    end
  endtask

  task automatic test_sync_zero();
    logic [7:0] f[6] = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'hE0};
    do_reset();
    foreach (f[i]) send(f[i]);
    n_cmp++;
    if (sync_miss !== 8'd2 || {frame_valid, frame_len} !== {1'b1, 8'h00} || wq.size() != 0) begin
      n_bad++; $display("FAIL sync_zero: got miss=%0d v=%b len=%h writes=%0d want 2 1 00 0",
                        sync_miss, frame_valid, frame_len, wq.size());
    end
    send(8'h00); send(8'hA5); send(8'h33);
    n_cmp++;
    if (sync_miss !== 8'd2 || state !== 3'd5 || !hold) begin
      n_bad++; $display("FAIL hold_ignore: got miss=%0d st=%0d h=%b want 2 5 1", sync_miss, state, hold);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[6] = '{8'hA5, 8'h11, 8'h02, 8'h55, 8'h66, 8'h32};
    do_reset();
    send(8'hA5); send(8'h10); send(8'h04); send(8'h33);
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({hold, wr_en, wr_addr, wr_data, frame_valid, frame_cmd, frame_len,
         frame_err, err_code, sync_miss, busy, state} !== 48'h0) begin
      n_bad++; $display("FAIL reset_mid: got %h want 0", {hold, wr_en, wr_addr, wr_data,
               frame_valid, frame_cmd, frame_len, frame_err, err_code, sync_miss, busy, state});
    end
    reset = 1'b0;
    tick();
    clear_q();
    foreach (f[i]) send(f[i]);
    n_cmp++;
    if (wq.size() != 2 || wq[0] != 'h055 || wq[1] != 'h166 || !frame_valid || frame_cmd !== 8'h11) begin
      n_bad++; $display("FAIL reset_mid_restart: got writes=%0d v=%b cmd=%h want 2 (0:55 1:66) 1 11",
                        wq.size(), frame_valid, frame_cmd);
    end
    ack();
  endtask

  task automatic test_sync_sat();
    do_reset();
    repeat (260) send(8'h3C, 2);
    n_cmp++;
    if (sync_miss !== 8'd255) begin
      n_bad++; $display("FAIL sync_sat: got %0d want 255", sync_miss);
    end
  endtask

  task automatic test_random();
    int s[$];
    int kind, len, tot, b;
    bit ok;
    do_reset();
    exp_miss = 0;
    for (int it = 0; it < 20; it++) begin
      s.delete();
      repeat ($urandom_range(0, 2)) begin
        do b = $urandom_range(0, 255); while (b == SYNC);
        s.push_back(b);
      end
      kind = (it == 0) ? 0 : $urandom_range(0, 3);
      s.push_back(SYNC);
      s.push_back($urandom_range(0, 255));
      len = (it == 0) ? MAXL : (kind == 3) ? $urandom_range(MAXL + 1, 255) : $urandom_range(0, 8);
      s.push_back(len);
      if (kind != 3) begin
        tot = s[s.size()-2] + len;
        for (int k = 0; k < len; k++) begin
          b = $urandom_range(0, 255);
          s.push_back(b);
          tot += b;
        end
        b = (256 - (tot % 256)) % 256;
        if (kind == 2) b = (b + $urandom_range(1, 255)) % 256;
        s.push_back(b);
      end
      model(s);
      clear_q();
      foreach (s[i]) send(8'(s[i]));
      ok = (wq.size() == exp_w.size());
      if (ok) foreach (exp_w[i]) if (wq[i] != exp_w[i]) ok = 0;
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL rand_writes[%0d]: got %0d writes want %0d", it, wq.size(), exp_w.size());
      end
      ok = (eq.size() == exp_e.size());
      if (ok) foreach (exp_e[i]) if (eq[i] != exp_e[i]) ok = 0;
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL rand_errs[%0d]: got %0d errors want %0d", it, eq.size(), exp_e.size());
      end
      n_cmp++;
      if (int'(frame_valid) != exp_fv || int'(sync_miss) != exp_miss ||
          (exp_fv == 1 && (int'(frame_cmd) != exp_cmd || int'(frame_len) != exp_len))) begin
        n_bad++; $display("FAIL rand_frame[%0d]: got v=%b cmd=%h len=%h miss=%0d want v=%0d cmd=%h len=%h miss=%0d",
                          it, frame_valid, frame_cmd, frame_len, sync_miss, exp_fv, exp_cmd, exp_len, exp_miss);
      end
      if (exp_fv == 1) ack();
    end
  endtask

  initial begin
    reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; frame_ack = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_over();
    test_timeout();
    test_sync_zero();
    test_reset_mid();
    test_sync_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_frame_ctrl.md
# usb_frame_ctrl

Frame-level controller that sequences the USB byte reader. It consumes the single-cycle byte strobes, hunts for a sync byte, and parses command/length/payload/checksum frames. Payload bytes are written into an external buffer RAM. The block back-pressures the reader through its `hold` input while a completed frame waits for the downstream consumer, which releases it with `frame_ack`.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_LEN`, 64: largest legal payload length in bytes; must be ≤ 2^ADDR_W.
- `ADDR_W`, 6: buffer address width.
- `TIMEOUT`, 1000000: inter-byte timeout in clk cycles.
- `TO_W`, 20: timeout counter width; 2^TO_W > TIMEOUT.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `byte_in`  in  8  byte from the USB reader
- `byte_valid`  in  1  reader's new-data strobe
- `hold`  out  1  to the reader's hold input; freezes the reader
- `wr_en`  out  1  buffer write strobe
- `wr_addr`  out  ADDR_W  buffer write address
- `wr_data`  out  8  buffer write data
- `frame_valid`  out  1  a good frame is pending
- `frame_cmd`  out  8  command byte of the pending frame
- `frame_len`  out  8  payload length of the pending frame
- `frame_ack`  in  1  consumer releases the pending frame
- `frame_err`  out  1  one-cycle error pulse
- `err_code`  out  2  error cause: 1 = checksum, 2 = length, 3 = timeout; held until the next error
- `sync_miss`  out  8  saturating count of non-sync bytes discarded in IDLE
- `busy`  out  1  high in any state other than IDLE
- `state`  out  3  debug state

## Operation
- **Byte acceptance.** A byte is accepted on a cycle with `byte_valid`=1 and registered `hold`=0. `byte_valid` while `hold`=1 is ignored.
- **States and transitions:**
  - IDLE: on accept, a byte equal to SYNC_BYTE goes to CMD. Any other byte is discarded and `sync_miss` increments, saturating at 255.
  - CMD: on accept, latch the byte into `frame_cmd`, set `sum` = byte, go to LEN.
  - LEN: on accept, latch the byte into `frame_len` and add it to `sum`.
    - Byte > MAX_LEN: error code 2, go to IDLE.
    - Byte = 0: go to CSUM.
    - Otherwise: clear the index, go to PAYLOAD.
  - PAYLOAD: on accept, write the byte at `wr_addr` = index, add it to `sum`, increment the index. When index+1 = `frame_len`, go to CSUM.
  - CSUM: on accept, test (sum + byte) mod 256.
    - Result 0: go to DONE.
    - Nonzero: error code 1, go to IDLE.
  - DONE: `frame_valid`=1 and `hold`=1. On `frame_ack`=1, go to IDLE. `frame_ack` outside DONE is ignored.
- **Arithmetic.** `sum` is 8-bit and wraps. The checksum byte is the two's complement of cmd+len+payload.
- **Timeout.** In CMD, LEN, PAYLOAD and CSUM, a counter clears on every accepted byte and increments otherwise. When it reaches TIMEOUT: error code 3, go to IDLE. The counter is held at 0 in IDLE and DONE.
- **Errors.** Every error pulses `frame_err` for one cycle, updates `err_code`, and returns to IDLE. Payload bytes already written stay in the buffer. Downstream uses buffer contents only under `frame_valid`.
- **Reset, including mid-frame.**
  - Go to IDLE.
  - All outputs become 0: `hold`, `wr_en`, `wr_addr`, `wr_data`, `frame_valid`, `frame_cmd`, `frame_len`, `frame_err`, `err_code`, `sync_miss`, `busy`, `state`.
  - The timeout counter, `sum` and the index are cleared.
  - Buffer contents are untouched.

## Timing
- **Registered outputs.** All outputs are registered. Each transition takes effect at the clock edge following the accepting cycle.
- **Buffer writes.** A payload byte accepted in cycle t produces `wr_en`=1 in cycle t+1, with `wr_addr` and `wr_data` valid. `wr_en` is a single-cycle pulse.
- **Frame completion.** A good checksum byte accepted in cycle t raises `frame_valid` and `hold` in cycle t+1.
- **Release.** `frame_ack` in cycle t drops `frame_valid` and `hold` in cycle t+1. A new frame can be accepted from t+1.
- **Error pulses.** `frame_err` is high in the cycle after the offending byte or the timeout expiry.
- **Reader interaction.** `hold` rises only after a consumed byte. The reader has already cleared its strobe by then, because its minimum byte spacing is more than 10 cycles. No byte is lost or duplicated across `hold` edges.
- **Frame output stability.** `frame_cmd` and `frame_len` stay stable from `frame_valid` rise until the next LEN/CMD capture.

## Test plan
1. **Good frame.** Send A5 10 02 33 44 77.
   - Buffer writes: addr0=33, addr1=44.
   - Then `frame_valid`=1 with `frame_cmd`=10, `frame_len`=02, `hold`=1.
   - All three stay until `frame_ack`; 1 cycle after the ack, all drop to 0.
2. **Bad checksum.** Send A5 10 02 33 44 78.
   - `frame_err` pulses with `err_code`=1.
   - `frame_valid` and `hold` stay 0; state returns to IDLE.
3. **Length over limit.** Send A5 10 41.
   - `frame_err` with `err_code`=2 one cycle after the LEN byte, with no `wr_en`.
   - A following A5 20 00 E0 completes normally.
4. **Timeout.** With TIMEOUT=100, send A5 10, then no bytes.
   - `frame_err` with `err_code`=3 at the 100th cycle after the last accept, then IDLE.
5. **Sync hunt and zero length.** Send 00 FF A5 20 00 E0.
   - `sync_miss`=2.
   - `frame_valid` with `frame_len`=0 and no `wr_en`.
   - `byte_valid` pulses sent while `hold`=1 are ignored: `sync_miss` is unchanged and the state stays DONE.
6. **Reset mid-payload.** Assert `reset` after A5 10 04 33.
   - All outputs are 0 the next cycle.
   - A following good frame parses with index restarting at addr0.
